// File: rtl/color_freq_detector.sv
// Colour-sensor frequency detector: steps the sensor filter through G/R/B windows,
// counts synchronised pulse edges per window and reports the dominant colour.
// Optional clear-channel window and gating enabled by defining CD_CLEAR_CH_EN.
module color_freq_detector #(
    parameter int WINDOW_CYCLES = 500,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 4,
    parameter int TMR_W         = 10
) (
    input  logic             clk_1MHz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cs_out,
    output logic [1:0]       filter,
    output logic [1:0]       color,
    output logic             color_valid,
    output logic [CNT_W-1:0] red_freq,
    output logic [CNT_W-1:0] green_freq,
    output logic [CNT_W-1:0] blue_freq,
    output logic [CNT_W-1:0] clear_freq,
    output logic [CNT_W-1:0] pulse_counter,
    output logic [TMR_W-1:0] window_timer
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_G      = 3'd1;
    localparam logic [2:0] ST_R      = 3'd2;
    localparam logic [2:0] ST_B      = 3'd3;
`ifdef CD_CLEAR_CH_EN
    localparam logic [2:0] ST_C      = 3'd4;
`endif
    localparam logic [2:0] ST_DECIDE = 3'd5;

    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_COUNT);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [1:0]       sync_q;
    logic             sync_d;
    logic             edge_det;
    logic             measuring;
    logic             last_cycle;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] best;
    logic [1:0]       decision;

    // Two-flop synchroniser on the asynchronous pin, then rising-edge detect.
    assign edge_det = sync_q[1] & ~sync_d;

`ifdef CD_CLEAR_CH_EN
    assign measuring = (state == ST_G) || (state == ST_R) || (state == ST_B) || (state == ST_C);
`else
    assign measuring = (state == ST_G) || (state == ST_R) || (state == ST_B);
`endif
    assign last_cycle = measuring && (window_timer == LAST_TICK);

    // Saturating increment: a full counter stays put instead of wrapping.
    assign cnt_next = (edge_det && !(&pulse_counter)) ? pulse_counter + CNT_W'(1) : pulse_counter;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   next_state = ST_G;
            ST_G:      if (last_cycle) next_state = ST_R;
            ST_R:      if (last_cycle) next_state = ST_B;
`ifdef CD_CLEAR_CH_EN
            ST_B:      if (last_cycle) next_state = ST_C;
            ST_C:      if (last_cycle) next_state = ST_DECIDE;
`else
            ST_B:      if (last_cycle) next_state = ST_DECIDE;
`endif
            ST_DECIDE: next_state = ST_G;
            default:   next_state = ST_IDLE;
        endcase
        if (!en) next_state = ST_IDLE;
    end

    always_comb begin
        filter = 2'd2;
        case (state)
            ST_G:    filter = 2'd3;
            ST_R:    filter = 2'd0;
            ST_B:    filter = 2'd1;
            default: filter = 2'd2;
        endcase
    end

    // Red holds ties; a later channel must be strictly larger to take over.
    always_comb begin
        best     = red_freq;
        decision = 2'd1;
        if (green_freq > best) begin
            best     = green_freq;
            decision = 2'd2;
        end
        if (blue_freq > best) begin
            best     = blue_freq;
            decision = 2'd3;
        end
        if (best < MIN_CNT) decision = 2'd0;
`ifdef CD_CLEAR_CH_EN
        if (clear_freq < MIN_CNT) decision = 2'd0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sync_q        <= '0;
            sync_d        <= 1'b0;
            window_timer  <= '0;
            pulse_counter <= '0;
            red_freq      <= '0;
            green_freq    <= '0;
            blue_freq     <= '0;
            color         <= 2'd0;
            color_valid   <= 1'b0;
        end else begin
            state  <= next_state;
            sync_q <= {sync_q[0], cs_out};
            sync_d <= sync_q[1];

            // Window bookkeeping restarts on entry, on abort and outside measurement.
            if (!en || !measuring || last_cycle) begin
                window_timer  <= '0;
                pulse_counter <= '0;
            end else begin
                window_timer  <= window_timer + TMR_W'(1);
                pulse_counter <= cnt_next;
            end

            if (en && last_cycle) begin
                case (state)
                    ST_G:    green_freq <= cnt_next;
                    ST_R:    red_freq   <= cnt_next;
                    ST_B:    blue_freq  <= cnt_next;
                    default: ;
                endcase
            end

            color_valid <= en && (state == ST_DECIDE);
            if (en && (state == ST_DECIDE)) color <= decision;
        end
    end

`ifdef CD_CLEAR_CH_EN
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            clear_freq <= '0;
        end else if (en && last_cycle && (state == ST_C)) begin
            clear_freq <= cnt_next;
        end
    end
`else
    assign clear_freq = '0;
`endif

endmodule

// File: tb/tb_color_freq_detector.sv
// Scoreboard bench for color_freq_detector: a sensor model driven by the filter lines,
// a pin-history reference model that predicts each decision, and a valid-strobe monitor.
`timescale 1ns/1ps
module tb_color_freq_detector;

    localparam int W     = 200;
    localparam int CW    = 5;
    localparam int MINC  = 4;
    localparam int TW    = 8;
    localparam int MAXC  = (1 << CW) - 1;
`ifdef CD_CLEAR_CH_EN
    localparam int NCH   = 4;
`else
    localparam int NCH   = 3;
`endif
    localparam int L     = NCH * W + 1;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          cs_out;
    logic [1:0]    filter;
    logic [1:0]    color;
    logic          color_valid;
    logic [CW-1:0] red_freq, green_freq, blue_freq, clear_freq, pulse_counter;
    logic [TW-1:0] window_timer;

    color_freq_detector #(
        .WINDOW_CYCLES(W), .CNT_W(CW), .MIN_COUNT(MINC), .TMR_W(TW)
    ) dut (
        .clk_1MHz(clk), .rst_n(rst_n), .en(en), .cs_out(cs_out),
        .filter(filter), .color(color), .color_valid(color_valid),
        .red_freq(red_freq), .green_freq(green_freq), .blue_freq(blue_freq),
        .clear_freq(clear_freq), .pulse_counter(pulse_counter), .window_timer(window_timer)
    );

    typedef struct {
        int color;
        int r;
        int g;
        int b;
        int c;
    } exp_t;

    exp_t sb[$];
    bit   hist[$];
    int   cyc;
    int   per_tab[4];
    int   checks;
    int   errors;
    int   pushes;
    int   valids;
    int   exp_r, exp_g, exp_b, exp_c;

    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Sensor model: square wave whose period follows the selected filter.
    // hist[k] is the pin level seen by the design at posedge k.
    initial begin
        int ph;
        int p;
        ph     = 0;
        cyc    = 0;
        cs_out = 1'b0;
        hist.push_back(1'b0);
        forever begin
            @(posedge clk);
            cyc++;
            hist.push_back(cs_out);
            #2;
            ph++;
            p = per_tab[filter];
            cs_out = (p == 0) ? 1'b0 : ((ph % p) < (p / 2));
        end
    end

    // Edges counted at posedges s+1 .. s+len; an edge reaches the counter 3 clocks after the pin.
    function automatic int count_edges(input int s, input int len);
        int n;
        n = 0;
        for (int q = s + 1; q <= s + len; q++)
            if (hist[q-2] && !hist[q-3]) n++;
        return (n > MAXC) ? MAXC : n;
    endfunction

    function automatic int model_color(input int r, input int g, input int b, input int c);
        int mx;
        int col;
        mx  = (r > g) ? r : g;
        mx  = (mx > b) ? mx : b;
        col = (r == mx) ? 1 : ((g == mx) ? 2 : 3);
        if (mx < MINC) col = 0;
`ifdef CD_CLEAR_CH_EN
        if (c < MINC) col = 0;
`endif
        return col;
    endfunction

    task automatic wait_neg(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic set_periods(input int pg, input int pr, input int pb, input int pc);
        per_tab[3] = pg;
        per_tab[0] = pr;
        per_tab[1] = pb;
        per_tab[2] = pc;
    endtask

    task automatic run(input int loops);
        int p0;
        int base;
        exp_t e;
        @(negedge clk);
        en = 1'b1;
        p0 = cyc + 1;
        for (int n = 0; n < loops; n++) begin
            base = p0 + n * L;
            wait_neg(base + 37);
            check("filter_g", int'(filter), 3);
            if (n == 0) begin
                check("window_timer_live", int'(window_timer), 37);
                check("pulse_counter_live", int'(pulse_counter), count_edges(base, 37));
            end
            wait_neg(base + W + 5);
            check("filter_r", int'(filter), 0);
            wait_neg(base + 2 * W + 5);
            check("filter_b", int'(filter), 1);
`ifdef CD_CLEAR_CH_EN
            wait_neg(base + 3 * W + 5);
            check("filter_c", int'(filter), 2);
`endif
            wait_neg(base + NCH * W);
            check("filter_decide", int'(filter), 2);
            e.g = count_edges(base, W);
            e.r = count_edges(base + W, W);
            e.b = count_edges(base + 2 * W, W);
`ifdef CD_CLEAR_CH_EN
            e.c = count_edges(base + 3 * W, W);
`else
            e.c = 0;
`endif
            e.color = model_color(e.r, e.g, e.b, e.c);
            exp_r = e.r; exp_g = e.g; exp_b = e.b; exp_c = e.c;
            sb.push_back(e);
            pushes++;
        end
        wait_neg(p0 + loops * L);
        en = 1'b0;
        wait_neg(p0 + loops * L + 1);
        check("idle_filter", int'(filter), 2);
        check("idle_red_hold", int'(red_freq), exp_r);
    endtask

    // Monitor: every valid strobe pops the oldest prediction.
    initial begin
        exp_t e;
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && color_valid) begin
                valids++;
                if (prev_valid) check("valid_one_cycle", 1, 0);
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("color", int'(color), e.color);
                    check("red_freq", int'(red_freq), e.r);
                    check("green_freq", int'(green_freq), e.g);
                    check("blue_freq", int'(blue_freq), e.b);
                    check("clear_freq", int'(clear_freq), e.c);
                end
            end
            prev_valid = rst_n && color_valid;
        end
    end

    initial begin
        #(90_000_000);
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        checks = 0; errors = 0; pushes = 0; valids = 0;
        exp_r = 0; exp_g = 0; exp_b = 0; exp_c = 0;
        en    = 1'b0;
        rst_n = 1'b0;
        set_periods(0, 0, 0, 0);
        repeat (5) @(negedge clk);
        check("rst_filter", int'(filter), 2);
        check("rst_color", int'(color), 0);
        check("rst_valid", int'(color_valid), 0);
        check("rst_counter", int'(pulse_counter), 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_filter0", int'(filter), 2);
        check("idle_valid0", int'(color_valid), 0);
        check("idle_red0", int'(red_freq), 0);
        check("idle_timer0", int'(window_timer), 0);
        en = 1'b1;
        @(negedge clk);
        check("enable_to_g", int'(filter), 3);
        en = 1'b0;
        repeat (3) @(negedge clk);

        // Red dominant, then red/green/blue in turn, stuck low, tie, saturation.
        set_periods(20, 10, 25, 10); run(2);
        set_periods(20, 8, 30, 10);  run(1);
        set_periods(8, 20, 30, 10);  run(1);
        set_periods(30, 20, 8, 10);  run(1);
        set_periods(0, 0, 0, 0);     run(1);
        check("stuck_low_color", int'(color), 0);
        set_periods(10, 10, 10, 10); run(1);
        check("tie_color", int'(color), 1);
        set_periods(12, 4, 12, 10);  run(1);
        check("sat_red", int'(red_freq), MAXC);
`ifdef CD_CLEAR_CH_EN
        set_periods(20, 10, 25, 0);  run(1);
        check("clear_gate_color", int'(color), 0);
`endif

        // Abort in the middle of the red window.
        set_periods(6, 14, 9, 10);
        @(negedge clk);
        en = 1'b1;
        p0 = cyc + 1;
        wait_neg(p0 + W + 100);
        check("abort_timer", int'(window_timer), 100);
        en = 1'b0;
        wait_neg(p0 + W + 101);
        exp_g = count_edges(p0, W);
        check("abort_filter", int'(filter), 2);
        check("abort_counter", int'(pulse_counter), 0);
        check("abort_red_hold", int'(red_freq), exp_r);
        check("abort_green_new", int'(green_freq), exp_g);
        run(1);

        // Asynchronous reset in the middle of the blue window.
        set_periods(9, 7, 11, 10);
        @(negedge clk);
        en = 1'b1;
        p0 = cyc + 1;
        wait_neg(p0 + 2 * W + 50);
        rst_n = 1'b0;
        #1;
        check("mid_rst_filter", int'(filter), 2);
        check("mid_rst_red", int'(red_freq), 0);
        check("mid_rst_green", int'(green_freq), 0);
        check("mid_rst_counter", int'(pulse_counter), 0);
        check("mid_rst_timer", int'(window_timer), 0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Randomised periods (0 = stuck low, otherwise 4..40 clocks).
        for (int i = 0; i < 6; i++) begin
            int pg, pr, pb;
            pg = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(4, 40));
            pr = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(4, 40));
            pb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(4, 40));
            set_periods(pg, pr, pb, int'($urandom_range(4, 30)));
            run(2);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("valid_count", valids, pushes);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
